datamem_serial_resp: RTL

- Data-memory responder for the MEM-stage data memory interface.
- The MEM stage drives datamem_en, readwrite, size, address and store data. This block executes the access against a byte-wide storage array, one byte per cycle.
- Signals busy so the pipeline can stall, and pulses done when the access completes.
- Byte order is big-endian, the same order used for instruction-memory preload.

---
 rtl/datamem_serial_resp_if.sv | 16 +
 rtl/datamem_serial_resp.sv | 120 ++++++++++++
 2 files changed

// File: rtl/datamem_serial_resp_if.sv
// datamem_serial_resp_if: MEM-stage data-memory request/response bundle.
interface datamem_serial_resp_if #(parameter int ADDR_W = 9);
    logic              datamem_en;
    logic              readwrite;
    logic              size;
    logic [ADDR_W-1:0] address;
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic              busy;
    logic              done;
    logic              align_err;
    modport master (output datamem_en, readwrite, size, address, data_in,
                    input  data_out, busy, done, align_err);
    modport slave  (input  datamem_en, readwrite, size, address, data_in,
                    output data_out, busy, done, align_err);
endinterface

// File: rtl/datamem_serial_resp.sv
// datamem_serial_resp: byte-serial big-endian data memory responder with busy/done handshake.
// Optional DATAMEM_ALIGN_CHECK_EN rejects misaligned word accesses with align_err.
module datamem_serial_resp #(
    parameter int ADDR_W = 9
) (
    input logic                 clk,
    input logic                 reset,
    datamem_serial_resp_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [7:0]        mem [2**ADDR_W];
    logic [1:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic              size_q, size_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       shadow_q, shadow_d;
    logic [31:0]       dout_q, dout_d;
    logic [ADDR_W-1:0] baddr;
    logic [7:0]        rbyte;
    logic [4:0]        lane_sh;
    logic [31:0]       wshift;
    logic [31:0]       merged;
    logic              last;
    logic              mem_we;

    // Word byte k lives in lane 3-k (big-endian); ~cnt_q equals 3-k.
    assign lane_sh = {~cnt_q, 3'b000};
    assign baddr   = addr_q + ADDR_W'(cnt_q);
    assign rbyte   = mem[baddr];
    assign wshift  = size_q ? (wdata_q >> lane_sh) : wdata_q;
    assign merged  = (shadow_q & ~(32'hFF << lane_sh)) | (32'(rbyte) << lane_sh);
    assign last    = ~size_q | (cnt_q == 2'd3);
    assign mem_we  = (state_q == XFER) & rw_q;

    assign bus.busy     = state_q != IDLE;
    assign bus.done     = state_q == RESP;
    assign bus.data_out = dout_q;

`ifdef DATAMEM_ALIGN_CHECK_EN
    logic err_q, err_d;
    assign bus.align_err = (state_q == RESP) & err_q;
`else
    assign bus.align_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        size_d   = size_q;
        wdata_d  = wdata_q;
        shadow_d = shadow_q;
        dout_d   = dout_q;
`ifdef DATAMEM_ALIGN_CHECK_EN
        err_d    = err_q;
`endif
        if (state_q == IDLE) begin
            if (bus.datamem_en) begin
                addr_d  = bus.size ? {bus.address[ADDR_W-1:2], 2'b00} : bus.address;
                rw_d    = bus.readwrite;
                size_d  = bus.size;
                wdata_d = bus.data_in;
                cnt_d   = 2'd0;
                state_d = XFER;
`ifdef DATAMEM_ALIGN_CHECK_EN
                err_d   = bus.size & (bus.address[1:0] != 2'b00);
                state_d = err_d ? RESP : XFER;
`endif
            end
        end else if (state_q == XFER) begin
            cnt_d    = cnt_q + 2'd1;
            shadow_d = rw_q ? shadow_q : merged;
            if (last) begin
                state_d = RESP;
                dout_d  = rw_q ? dout_q : (size_q ? merged : {24'h0, rbyte});
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            size_q   <= 1'b0;
            wdata_q  <= 32'h0;
            shadow_q <= 32'h0;
            dout_q   <= 32'h0;
`ifdef DATAMEM_ALIGN_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            size_q   <= size_d;
            wdata_q  <= wdata_d;
            shadow_q <= shadow_d;
            dout_q   <= dout_d;
`ifdef DATAMEM_ALIGN_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    // Storage survives reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[baddr] <= wshift[7:0];
    end
endmodule
